// File: rtl/interleaver_ingest_ctrl.sv
// interleaver_ingest_ctrl: accepts one byte-serial block (1056 or 6144 bits) into the
// interleaver shift register, then sequences the bit-serial readout index.
module interleaver_ingest_ctrl #(
  parameter int BYTES_1056 = 132,
  parameter int BYTES_6144 = 768
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        k_size_6144_in,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        byte_sob,
  output logic        byte_ready,
  output logic [7:0]  databyte_out,
  output logic        shift_en,
  output logic        k_size_6144_out,
  output logic        ready_out,
  output logic [13:0] bit_idx,
  output logic        block_done,
  output logic        proto_err
);
  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, DRAIN} state_t;
  state_t      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [13:0] bit_q, bit_d;
  logic [7:0]  data_q, data_d;
  logic        rdy_q, rdy_d, sh_q, sh_d, k_q, k_d, rout_q, rout_d, done_q, done_d, perr_q, perr_d;
  logic        xfer, emit, last_bit;
  logic [9:0]  n_bytes;
  assign xfer     = byte_valid && rdy_q;
  assign n_bytes  = k_q ? 10'(BYTES_6144) : 10'(BYTES_1056);
  assign last_bit = bit_q == (k_q ? 14'd6143 : 14'd1055);
  assign emit     = xfer && ((state_q == IDLE && byte_sob) || (state_q == LOAD && !byte_sob));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    rdy_d   = rdy_q;
    k_d     = k_q;
    rout_d  = rout_q;
    done_d  = 1'b0;
    sh_d    = emit;
    data_d  = emit ? byte_in : data_q;
    perr_d  = xfer && ((state_q == IDLE && !byte_sob) || (state_q == LOAD && byte_sob));
    case (state_q)
      IDLE: begin
        rdy_d = 1'b1;
        if (emit) begin
          k_d     = k_size_6144_in;
          cnt_d   = 10'd1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (emit) begin
          cnt_d = cnt_q + 10'd1;
          if (cnt_q + 10'd1 == n_bytes) begin
            rdy_d   = 1'b0;
            state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        state_d = DRAIN;
        bit_d   = 14'd0;
      end
      default: begin
        // first DRAIN cycle only raises ready_out, so the readout starts two edges after the last accept
        if (!rout_q) rout_d = 1'b1;
        else if (last_bit) begin
          rout_d  = 1'b0;
          done_d  = 1'b1;
          bit_d   = 14'd0;
          rdy_d   = 1'b1;
          cnt_d   = 10'd0;
          state_d = IDLE;
        end else bit_d = bit_q + 14'd1;
      end
    endcase
  end
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      sh_q    <= 1'b0;
      k_q     <= 1'b0;
      rout_q  <= 1'b0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      sh_q    <= sh_d;
      k_q     <= k_d;
      rout_q  <= rout_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
    end
  end
  assign byte_ready      = rdy_q;
  assign databyte_out    = data_q;
  assign shift_en        = sh_q;
  assign k_size_6144_out = k_q;
  assign ready_out       = rout_q;
  assign bit_idx         = bit_q;
  assign block_done      = done_q;
  assign proto_err       = perr_q;
endmodule

// File: tb/tb_interleaver_ingest_ctrl.sv
// tb_interleaver_ingest_ctrl: directed scenarios for the interleaver ingest controller,
// with a negedge monitor collecting event counts that each scenario task checks.
module tb_interleaver_ingest_ctrl;
  logic        clock = 1'b0, rst = 1'b0, k_in = 1'b0, byte_valid = 1'b0, byte_sob = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_ready, shift_en, k_out, ready_out, block_done, proto_err;
  logic [7:0]  databyte_out;
  logic [13:0] bit_idx;
  int total = 0, bad = 0, cyc = 0;
  int shift_cnt = 0, xfer_cnt = 0, done_cnt = 0, perr_cnt = 0, bit_err = 0;
  int run = 0, last_run = 0, rise_cyc = 0, acc_cyc = 0;
  logic [13:0] exp_bit = 14'd0;
  logic [7:0]  cap [0:8191];

  interleaver_ingest_ctrl dut (
    .clock(clock), .rst(rst), .k_size_6144_in(k_in), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_sob(byte_sob), .byte_ready(byte_ready),
    .databyte_out(databyte_out), .shift_en(shift_en), .k_size_6144_out(k_out),
    .ready_out(ready_out), .bit_idx(bit_idx), .block_done(block_done), .proto_err(proto_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (shift_en) begin
      cap[shift_cnt] <= databyte_out;
      shift_cnt <= shift_cnt + 1;
    end
    if (byte_valid && byte_ready) begin
      xfer_cnt <= xfer_cnt + 1;
      acc_cyc <= cyc;
    end
    if (block_done) done_cnt <= done_cnt + 1;
    if (proto_err) perr_cnt <= perr_cnt + 1;
    if (ready_out) begin
      if (bit_idx !== exp_bit) bit_err <= bit_err + 1;
      exp_bit <= exp_bit + 14'd1;
      if (run == 0) rise_cyc <= cyc;
      run <= run + 1;
    end else begin
      exp_bit <= 14'd0;
      if (run != 0) begin
        last_run <= run;
        run <= 0;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic sob);
    int g = 0;
    logic ok = 1'b0;
    byte_in = b;
    byte_sob = sob;
    byte_valid = 1'b1;
    while (!ok) begin
      @(negedge clock);
      ok = byte_ready;
      tick();
      g++;
      if (g > 20000) begin
        $display("FAIL send_timeout: byte_ready=0 for %0d cycles, required 1", g);
        $fatal(1);
      end
    end
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic wait_done(input int d0, input int lim, input string name);
    int g = 0;
    while (done_cnt == d0 && g < lim) begin
      tick();
      g++;
    end
    total++;
    if (done_cnt == d0) begin
      bad++;
      $display("FAIL %s: block_done not seen within %0d cycles", name, lim);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    total++;
    if ({byte_ready, shift_en, databyte_out, k_out, ready_out, bit_idx, block_done, proto_err} !== 28'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h required 0",
               {byte_ready, shift_en, databyte_out, k_out, ready_out, bit_idx, block_done, proto_err});
    end
    @(posedge clock);
    #3 rst = 1'b1;
    #1;
    total++;
    if (byte_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_before_edge: got %b required 0", byte_ready); end
    tick();
    total++;
    if (byte_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after_edge: got %b required 1", byte_ready); end
  endtask

  task automatic test_k0_block();
    int s0 = shift_cnt, d0 = done_cnt, p0 = perr_cnt, b0 = bit_err;
    k_in = 1'b0;
    for (int i = 0; i < 132; i++) send(8'(i * 7 + 3), i == 0);
    byte_valid = 1'b0;
    wait_done(d0, 3000, "k0_done");
    repeat (5) tick();
    total++;
    if (shift_cnt - s0 !== 132) begin bad++; $display("FAIL k0_shift_count: got %0d required 132", shift_cnt - s0); end
    for (int i = 0; i < 132; i++) begin
      total++;
      if (cap[s0 + i] !== 8'(i * 7 + 3)) begin bad++; $display("FAIL k0_data[%0d]: got %h required %h", i, cap[s0 + i], 8'(i * 7 + 3)); end
    end
    total++;
    if (last_run !== 1056) begin bad++; $display("FAIL k0_ready_len: got %0d required 1056", last_run); end
    total++;
    if (rise_cyc !== acc_cyc + 3) begin bad++; $display("FAIL k0_latency: ready rose at edge %0d required %0d", rise_cyc, acc_cyc + 3); end
    total++;
    if (bit_err !== b0) begin bad++; $display("FAIL k0_bit_idx: %0d wrong indices, required 0", bit_err - b0); end
    total++;
    if (done_cnt - d0 !== 1) begin bad++; $display("FAIL k0_done_count: got %0d required 1", done_cnt - d0); end
    total++;
    if (perr_cnt !== p0) begin bad++; $display("FAIL k0_proto_err: got %0d required 0", perr_cnt - p0); end
    total++;
    if (k_out !== 1'b0) begin bad++; $display("FAIL k0_k_out: got %b required 0", k_out); end
  endtask

  task automatic test_k1_gaps();
    int s0 = shift_cnt, d0 = done_cnt, b0 = bit_err;
    k_in = 1'b1;
    for (int i = 0; i < 768; i++) begin
      send(8'(i * 13 + 5), i == 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    byte_valid = 1'b0;
    tick();
    total++;
    if (k_out !== 1'b1) begin bad++; $display("FAIL k1_k_out_load: got %b required 1", k_out); end
    wait_done(d0, 8000, "k1_done");
    total++;
    if (shift_cnt - s0 !== 768) begin bad++; $display("FAIL k1_shift_count: got %0d required 768", shift_cnt - s0); end
    for (int i = 0; i < 768; i++) begin
      total++;
      if (cap[s0 + i] !== 8'(i * 13 + 5)) begin bad++; $display("FAIL k1_data[%0d]: got %h required %h", i, cap[s0 + i], 8'(i * 13 + 5)); end
    end
    total++;
    if (last_run !== 6144) begin bad++; $display("FAIL k1_ready_len: got %0d required 6144", last_run); end
    total++;
    if (bit_err !== b0) begin bad++; $display("FAIL k1_bit_idx: %0d wrong indices, required 0", bit_err - b0); end
    total++;
    if (k_out !== 1'b1) begin bad++; $display("FAIL k1_k_out_done: got %b required 1", k_out); end
  endtask

  task automatic test_proto_err();
    int s0 = shift_cnt, d0 = done_cnt, p0 = perr_cnt;
    k_in = 1'b0;
    send(8'hEE, 1'b0);
    idle(3);
    total++;
    if (perr_cnt - p0 !== 1) begin bad++; $display("FAIL perr_idle: got %0d pulses required 1", perr_cnt - p0); end
    total++;
    if (shift_cnt !== s0) begin bad++; $display("FAIL perr_idle_shift: got %0d shifts required 0", shift_cnt - s0); end
    for (int i = 0; i < 132; i++) begin
      if (i == 50) send(8'hCC, 1'b1);
      send(8'(i * 5 + 1), i == 0);
    end
    byte_valid = 1'b0;
    wait_done(d0, 3000, "perr_done");
    total++;
    if (perr_cnt - p0 !== 2) begin bad++; $display("FAIL perr_total: got %0d pulses required 2", perr_cnt - p0); end
    total++;
    if (shift_cnt - s0 !== 132) begin bad++; $display("FAIL perr_shift_count: got %0d required 132", shift_cnt - s0); end
    for (int i = 0; i < 132; i++) begin
      total++;
      if (cap[s0 + i] !== 8'(i * 5 + 1)) begin bad++; $display("FAIL perr_data[%0d]: got %h required %h", i, cap[s0 + i], 8'(i * 5 + 1)); end
    end
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt, p0, x0, s1, g = 0;
    k_in = 1'b0;
    for (int i = 0; i < 132; i++) send(8'(i + 9), i == 0);
    byte_in = 8'hA5;
    byte_sob = 1'b1;
    x0 = xfer_cnt;
    p0 = perr_cnt;
    s1 = shift_cnt + 1;
    while (!ready_out && g < 20) begin @(negedge clock); #1; g++; end
    total++;
    if (byte_ready !== 1'b0 || ready_out !== 1'b1) begin
      bad++;
      $display("FAIL b2b_drain_ready: byte_ready=%b ready_out=%b required 0 and 1", byte_ready, ready_out);
    end
    g = 0;
    while (done_cnt == d0 && g < 3000) begin @(negedge clock); #1; g++; end
    total++;
    if (byte_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_at_done: got %b required 1", byte_ready); end
    total++;
    if (xfer_cnt - x0 !== 1) begin bad++; $display("FAIL b2b_transfers: got %0d required 1", xfer_cnt - x0); end
    total++;
    if (perr_cnt !== p0) begin bad++; $display("FAIL b2b_proto_err: got %0d required 0", perr_cnt - p0); end
    @(posedge clock);
    #1;
    d0 = done_cnt;
    byte_sob = 1'b0;
    for (int i = 1; i < 132; i++) send(8'(i * 3), 1'b0);
    byte_valid = 1'b0;
    wait_done(d0, 3000, "b2b_done");
    total++;
    if (cap[s1] !== 8'hA5) begin bad++; $display("FAIL b2b_first_byte: got %h required a5", cap[s1]); end
    total++;
    if (cap[s1 + 131] !== 8'(131 * 3)) begin bad++; $display("FAIL b2b_last_byte: got %h required %h", cap[s1 + 131], 8'(131 * 3)); end
    total++;
    if (last_run !== 1056) begin bad++; $display("FAIL b2b_ready_len: got %0d required 1056", last_run); end
  endtask

  task automatic test_reset_abort();
    int d0 = done_cnt, p0 = perr_cnt, s0, g = 0;
    k_in = 1'b1;
    for (int i = 0; i < 300; i++) send(8'(i), i == 0);
    byte_valid = 1'b0;
    rst = 1'b0;
    #1;
    total++;
    if ({byte_ready, shift_en, databyte_out, k_out, ready_out, bit_idx, block_done, proto_err} !== 28'd0) begin
      bad++;
      $display("FAIL abort_load_outputs: got %h required 0",
               {byte_ready, shift_en, databyte_out, k_out, ready_out, bit_idx, block_done, proto_err});
    end
    repeat (2) tick();
    @(negedge clock);
    rst = 1'b1;
    tick();
    total++;
    if (byte_ready !== 1'b1) begin bad++; $display("FAIL abort_load_release: got %b required 1", byte_ready); end
    for (int i = 0; i < 768; i++) send(8'(i), i == 0);
    byte_valid = 1'b0;
    while (!(ready_out && bit_idx == 14'd3000) && g < 10000) begin @(negedge clock); g++; end
    total++;
    if (bit_idx !== 14'd3000) begin bad++; $display("FAIL abort_drain_reach: got %0d required 3000", bit_idx); end
    #1 rst = 1'b0;
    #1;
    total++;
    if ({byte_ready, shift_en, databyte_out, k_out, ready_out, bit_idx, block_done, proto_err} !== 28'd0) begin
      bad++;
      $display("FAIL abort_drain_outputs: got %h required 0",
               {byte_ready, shift_en, databyte_out, k_out, ready_out, bit_idx, block_done, proto_err});
    end
    repeat (2) tick();
    @(negedge clock);
    rst = 1'b1;
    #1;
    total++;
    if (byte_ready !== 1'b0) begin bad++; $display("FAIL abort_drain_before_edge: got %b required 0", byte_ready); end
    tick();
    total++;
    if (byte_ready !== 1'b1) begin bad++; $display("FAIL abort_drain_release: got %b required 1", byte_ready); end
    total++;
    if (done_cnt !== d0 || perr_cnt !== p0) begin
      bad++;
      $display("FAIL abort_no_pulses: done=%0d perr=%0d required 0 and 0", done_cnt - d0, perr_cnt - p0);
    end
    s0 = shift_cnt;
    k_in = 1'b0;
    for (int i = 0; i < 132; i++) send(8'(i ^ 8'h5A), i == 0);
    byte_valid = 1'b0;
    wait_done(d0, 3000, "abort_fresh_done");
    total++;
    if (shift_cnt - s0 !== 132) begin bad++; $display("FAIL abort_fresh_shift: got %0d required 132", shift_cnt - s0); end
    total++;
    if (cap[s0 + 77] !== 8'(77 ^ 8'h5A)) begin bad++; $display("FAIL abort_fresh_data: got %h required %h", cap[s0 + 77], 8'(77 ^ 8'h5A)); end
    total++;
    if (last_run !== 1056) begin bad++; $display("FAIL abort_fresh_len: got %0d required 1056", last_run); end
  endtask

  task automatic test_k_toggle();
    int s0 = shift_cnt, d0 = done_cnt, g = 0;
    k_in = 1'b0;
    for (int i = 0; i < 132; i++) begin
      send(8'(i * 11), i == 0);
      k_in = ~k_in;
    end
    byte_valid = 1'b0;
    while (done_cnt == d0 && g < 3000) begin
      k_in = ~k_in;
      tick();
      g++;
      if (g == 600) begin
        total++;
        if (k_out !== 1'b0) begin bad++; $display("FAIL ktog_k_out_drain: got %b required 0", k_out); end
      end
    end
    total++;
    if (done_cnt - d0 !== 1) begin bad++; $display("FAIL ktog_done: got %0d required 1", done_cnt - d0); end
    total++;
    if (last_run !== 1056) begin bad++; $display("FAIL ktog_ready_len: got %0d required 1056", last_run); end
    total++;
    if (shift_cnt - s0 !== 132) begin bad++; $display("FAIL ktog_shift: got %0d required 132", shift_cnt - s0); end
    total++;
    if (k_out !== 1'b0) begin bad++; $display("FAIL ktog_k_out: got %b required 0", k_out); end
  endtask

  initial begin
    test_reset();
    test_k0_block();
    test_k1_gaps();
    test_proto_err();
    test_back_to_back();
    test_reset_abort();
    test_k_toggle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/interleaver_ingest_ctrl.md
INTERLEAVER_INGEST_CTRL -- requirements
Module: interleaver_ingest_ctrl

Interface
REQ-001 SHALL have parameter BYTES_1056, default 132, meaning the byte count of a K=1056 block.
REQ-002 SHALL have parameter BYTES_6144, default 768, meaning the byte count of a K=6144 block.
REQ-003 SHALL have these ports (name, direction, width, meaning):
- clock  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- k_size_6144_in  in  1  block size: 0 = 1056, 1 = 6144; sampled only on start-of-block acceptance.
- byte_in  in  8  upstream data byte.
- byte_valid  in  1  byte_in is valid.
- byte_sob  in  1  start-of-block marker, qualified by byte_valid.
- byte_ready  out  1  registered; transfer occurs when byte_valid && byte_ready.
- databyte_out  out  8  registered byte to the 6144-bit shift register.
- shift_en  out  1  registered; databyte_out is valid this cycle.
- k_size_6144_out  out  1  latched block size for the interleaver.
- ready_out  out  1  block fully loaded; bit-serial readout in progress.
- bit_idx  out  14  readout index, 0..K-1, valid while ready_out = 1.
- block_done  out  1  one-cycle pulse after the final readout cycle.
- proto_err  out  1  one-cycle pulse on a protocol violation.

Function
REQ-004 SHALL implement FSM states IDLE, LOAD, SETTLE, DRAIN.
REQ-005 SHALL define N = BYTES_6144 if latched k = 1, else BYTES_1056; K = 6144 or 1056 respectively.
REQ-006 IDLE: byte_ready = 1; on transfer with byte_sob = 1: latch k_size_6144_in into k_size_6144_out, set byte_cnt = 1, emit the byte, go to LOAD.
REQ-007 IDLE: on transfer with byte_sob = 0: byte discarded, no shift_en, proto_err pulse, remain in IDLE.
REQ-008 Emitting a byte: at the accepting edge, databyte_out <= byte_in and shift_en <= 1; shift_en is 0 in any cycle following an edge with no emitted byte.
REQ-009 LOAD: byte_ready = 1; each transfer with byte_sob = 0 emits the byte and increments byte_cnt (10 bits).
REQ-010 LOAD: a transfer with byte_sob = 1 is discarded, pulses proto_err, and leaves byte_cnt unchanged.
REQ-011 LOAD: the transfer that makes byte_cnt = N clears byte_ready at the same edge and moves to SETTLE; no further byte is accepted until the next IDLE.
REQ-012 SETTLE: lasts exactly 1 cycle (the cycle in which the last shift_en is high), then moves to DRAIN with bit_idx = 0.
REQ-013 DRAIN: ready_out = 1 for exactly K consecutive cycles; bit_idx increments by 1 per cycle, from 0 to K-1.
REQ-014 On the edge leaving bit_idx = K-1: ready_out <= 0, block_done <= 1 for one cycle, bit_idx <= 0, byte_ready <= 1, state <= IDLE.
REQ-015 byte_valid activity outside IDLE/LOAD is ignored, with no proto_err.
REQ-016 Gaps (byte_valid = 0) during LOAD are unlimited; there is no timeout.
REQ-017 k_size_6144_in changes after the SOB transfer have no effect until the next SOB transfer in IDLE.
REQ-018 ready_out, bit_idx and k_size_6144_out are registered outputs with no combinational input-to-output path.
REQ-019 Latency: the last byte is accepted at edge E; shift_en is high during E..E+1; ready_out rises at edge E+2.

Reset
REQ-020 While rst = 0, asynchronously: state = IDLE, byte_cnt = 0, bit_idx = 0, and byte_ready, shift_en, databyte_out, k_size_6144_out, ready_out, block_done and proto_err all = 0.
REQ-021 byte_ready SHALL rise at the first rising clock edge after rst deasserts.
REQ-022 Reset asserted in any state aborts the block; the partial block is discarded, and no block_done or proto_err is generated.

Verification
REQ-023 k = 0, 132 back-to-back bytes with SOB on the first -> 132 shift_en pulses with data in order; ready_out high for exactly 1056 cycles, starting 2 edges after the last accept; bit_idx 0..1055; one block_done pulse.
REQ-024 k = 1, 768 bytes with random byte_valid gaps -> 768 shift_en pulses, byte_cnt unaffected by gaps; ready_out high for 6144 cycles; k_size_6144_out = 1 throughout.
REQ-025 Byte without SOB in IDLE, then a second SOB at byte 50 of a k = 0 block -> two proto_err pulses, neither byte emitted; block completes after 132 valid bytes.
REQ-026 byte_valid held high during DRAIN -> byte_ready = 0, no transfers, no proto_err; the next block is accepted immediately after block_done.
REQ-027 rst pulsed low during LOAD (byte 300 of 768) and during DRAIN (bit_idx 3000) -> all outputs 0 immediately; byte_ready = 1 one edge after release; a fresh k = 0 block then completes normally.
REQ-028 k_size_6144_in toggled during LOAD and DRAIN -> N, K and k_size_6144_out unchanged for the current block.
